fpga2cpu_pcie: RTL and testbench

- Transmit-side counterpart of the CPU-to-FPGA fetch path.
- Accepts 512-bit PDU metadata entries from the FPGA pipeline and stages them in an on-chip RAM whose slots mirror the CPU F2C ring-buffer slots.
- Issues write-data-mover (WRDM) descriptors that copy staged entries into CPU memory, then an immediate descriptor that publishes the new tail to CPU memory.
- Flow control comes from the CPU-maintained head index.

---
 rtl/fpga2cpu_pcie_pkg.sv | 68 ++++++
 rtl/f2c_stage_ram.sv | 51 +++++
 rtl/fpga2cpu_pcie.sv | 197 +++++++++++++++++++
 tb/tb_fpga2cpu_pcie.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga2cpu_pcie_pkg.sv
// fpga2cpu_pcie_pkg
//   Shared types and constants for the FPGA-to-CPU F2C transmit path:
//   ring geometry, the WRDM descriptor layout, the tail-update descriptor
//   ID, FSM state encodings and descriptor builder helpers.
package fpga2cpu_pcie_pkg;

    localparam int F2C_RB_AWIDTH = 9;
    localparam int F2C_RB_DEPTH  = 1 << F2C_RB_AWIDTH;

    localparam logic [7:0] TAIL_ID = 8'hFE;

    // 174-bit WRDM descriptor. For data moves the 32 bits between func and
    // dst carry a plain dword count (id/app/single/imm all zero), so the
    // count lives in the low bits of that word.
    typedef struct packed {
        logic [13:0] func;
        logic [7:0]  id;
        logic [2:0]  app;
        logic        single;
        logic        imm;
        logic [18:0] dwords;
        logic [63:0] dst;
        logic [63:0] src;
    } wrdm_desc_t;

    localparam int WRDM_DESC_W = $bits(wrdm_desc_t);

    // State encodings kept as plain constants for compatibility with the
    // older blocks that decode them.
    typedef logic [2:0] f2c_state_t;
    localparam f2c_state_t IDLE      = 3'd0;
    localparam f2c_state_t DESC      = 3'd1;
    localparam f2c_state_t DESC_LOW  = 3'd2;
    localparam f2c_state_t DESC_HIGH = 3'd3;
    localparam f2c_state_t TAIL      = 3'd4;

    // Copy 'entries' 64-byte slots starting at 'slot' from staging RAM to
    // the CPU ring. Slot offsets are identical on both sides.
    function automatic wrdm_desc_t make_data_desc(
        input logic [63:0]              kmem,
        input logic [31:0]              ep_base,
        input logic [F2C_RB_AWIDTH-1:0] slot,
        input logic [F2C_RB_AWIDTH:0]   entries
    );
        wrdm_desc_t d;
        d        = '0;
        d.dwords = {5'd0, entries, 4'd0};           // 16 dwords per entry
        d.dst    = kmem + (64'(slot) << 6);
        d.src    = {32'h0, ep_base + (32'(slot) << 6)};
        return d;
    endfunction

    // Immediate single-dword write of the new tail into the CPU shadow word.
    function automatic wrdm_desc_t make_tail_desc(
        input logic [63:0]              tail_addr,
        input logic [F2C_RB_AWIDTH-1:0] new_tail
    );
        wrdm_desc_t d;
        d        = '0;
        d.id     = TAIL_ID;
        d.imm    = 1'b1;
        d.dwords = 19'd1;
        d.dst    = tail_addr;
        d.src    = 64'(new_tail);
        return d;
    endfunction

endpackage

// File: rtl/f2c_stage_ram.sv
// f2c_stage_ram
//   Simple dual-port staging RAM, one 512-bit word per ring slot.
//   Write port is single-cycle; the read port is a 2-stage registered read
//   so read data and its valid appear exactly 2 cycles after rd_en.
//   Ports:
//     clk, rst          clock, synchronous active-high reset (valid pipe only)
//     wr_en/addr/data   write port
//     rd_en/rd_addr     read request
//     rd_data/rd_valid  read response, 2 cycles after rd_en
module f2c_stage_ram #(
    parameter int DW = 512,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_stage_q;
    logic [DW-1:0] rd_data_q;
    logic [1:0]    vld_pipe_q, vld_pipe_d;

    // Memory array and data stages carry no reset so they map onto block RAM
    // with its output register.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_stage_q <= mem[rd_addr];
        rd_data_q <= rd_stage_q;
    end

    always_comb begin
        vld_pipe_d = {vld_pipe_q[0], rd_en};
    end

    always_ff @(posedge clk) begin
        if (rst) vld_pipe_q <= '0;
        else     vld_pipe_q <= vld_pipe_d;
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = vld_pipe_q[1];

endmodule

// File: rtl/fpga2cpu_pcie.sv
// fpga2cpu_pcie
//   F2C transmit path. Metadata entries from the FPGA pipeline are staged in
//   an on-chip RAM whose slots mirror the CPU ring. Batches of staged entries
//   are copied to CPU memory with WRDM data descriptors (split in two when the
//   batch crosses the ring end), followed by an immediate descriptor that
//   publishes the new tail. The CPU-written head index gates new entries.
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     in_valid/in_ready/in_data     entry input stream
//     head                          CPU consumer index
//     tail                          last published producer index
//     kmem_addr, cpu_f2c_tail_addr  CPU ring base and tail shadow address
//     wrdm_desc_*                   descriptor stream to the WRDM queue
//     f2c_read/address/readdata/readdatavalid  WRDM read of staging RAM
//     sent_cnt                      running count of published entries
module fpga2cpu_pcie
    import fpga2cpu_pcie_pkg::*;
#(
    parameter logic [31:0] EP_BASE_ADDR  = 32'h0008_0000,
    parameter int          MAX_BATCH     = 64,
    parameter int          BATCH_MIN     = 8,
    parameter int          FLUSH_TIMEOUT = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [511:0]             in_data,
    input  logic [F2C_RB_AWIDTH-1:0] head,
    output logic [F2C_RB_AWIDTH-1:0] tail,
    input  logic [63:0]              kmem_addr,
    input  logic [63:0]              cpu_f2c_tail_addr,
    input  logic                     wrdm_desc_ready,
    output logic                     wrdm_desc_valid,
    output logic [WRDM_DESC_W-1:0]   wrdm_desc_data,
    input  logic                     f2c_read,
    input  logic [F2C_RB_AWIDTH-1:0] f2c_address,
    output logic [511:0]             f2c_readdata,
    output logic                     f2c_readdatavalid,
    output logic [31:0]              sent_cnt
);
    localparam int AW = F2C_RB_AWIDTH;
    localparam int CW = AW + 1;                     // entry count 0..DEPTH
    localparam int EW = AW + 2;                     // start+cnt before wrap
    localparam int TW = $clog2(FLUSH_TIMEOUT) + 1;

    f2c_state_t    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW-1:0] start_q, start_d;
    logic [AW-1:0] new_tail_q, new_tail_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] low_q, low_d;
    logic [CW-1:0] high_q, high_d;
    logic [TW-1:0] idle_timer_q, idle_timer_d;
    logic [31:0]   sent_cnt_q, sent_cnt_d;
    logic [63:0]   kmem_q, kmem_d;
    logic [63:0]   tail_addr_q, tail_addr_d;

    logic [AW-1:0] pend;
    logic [CW-1:0] batch_cnt;
    logic [CW-1:0] wrap_low;
    logic [EW-1:0] batch_end;
    logic          accept;
    logic          trigger;
    logic          desc_fire;
    wrdm_desc_t    desc;

    // One slot is always left empty so full and empty are distinguishable.
    assign in_ready = !rst && ((wr_ptr_q + AW'(1)) != head);
    assign accept   = in_valid && in_ready;

    f2c_stage_ram #(
        .DW (512),
        .AW (AW)
    ) u_stage_ram (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (accept),
        .wr_addr  (wr_ptr_q),
        .wr_data  (in_data),
        .rd_en    (f2c_read),
        .rd_addr  (f2c_address),
        .rd_data  (f2c_readdata),
        .rd_valid (f2c_readdatavalid)
    );

    // Batch sizing, evaluated against the live write pointer while idle.
    always_comb begin
        pend      = wr_ptr_q - tail_q;
        batch_cnt = ({1'b0, pend} > CW'(MAX_BATCH)) ? CW'(MAX_BATCH) : {1'b0, pend};
        batch_end = EW'(tail_q) + EW'(batch_cnt);
        wrap_low  = CW'(F2C_RB_DEPTH) - CW'(tail_q);
        trigger   = (state_q == IDLE) &&
                    (({1'b0, pend} >= CW'(BATCH_MIN)) ||
                     ((pend != '0) && (idle_timer_q >= TW'(FLUSH_TIMEOUT - 1))));
    end

    // Descriptor contents depend only on values latched at batch start, so
    // the presented word cannot change while the queue back-pressures.
    always_comb begin
        desc = make_tail_desc(tail_addr_q, new_tail_q);
        case (state_q)
            DESC:      desc = make_data_desc(kmem_q, EP_BASE_ADDR, start_q, cnt_q);
            DESC_LOW:  desc = make_data_desc(kmem_q, EP_BASE_ADDR, start_q, low_q);
            DESC_HIGH: desc = make_data_desc(kmem_q, EP_BASE_ADDR, '0, high_q);
            default:   ;
        endcase
    end

    assign wrdm_desc_valid = (state_q != IDLE);
    assign wrdm_desc_data  = desc;
    assign desc_fire       = wrdm_desc_valid && wrdm_desc_ready;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        tail_d       = tail_q;
        start_d      = start_q;
        new_tail_d   = new_tail_q;
        cnt_d        = cnt_q;
        low_d        = low_q;
        high_d       = high_q;
        idle_timer_d = idle_timer_q;
        sent_cnt_d   = sent_cnt_q;
        kmem_d       = kmem_q;
        tail_addr_d  = tail_addr_q;

        // Flush timer: counts idle cycles with work pending, restarts on
        // every batch launch and whenever the ring drains.
        if (pend == '0)
            idle_timer_d = '0;
        else if (state_q == IDLE)
            idle_timer_d = trigger ? '0 : idle_timer_q + TW'(1);

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    start_d     = tail_q;
                    cnt_d       = batch_cnt;
                    new_tail_d  = batch_end[AW-1:0];
                    low_d       = wrap_low;
                    high_d      = batch_cnt - wrap_low;
                    kmem_d      = kmem_addr;
                    tail_addr_d = cpu_f2c_tail_addr;
                    // Ending exactly at DEPTH needs no split.
                    state_d     = (batch_end <= EW'(F2C_RB_DEPTH)) ? DESC : DESC_LOW;
                end
            end
            DESC:      if (desc_fire) state_d = TAIL;
            DESC_LOW:  if (desc_fire) state_d = DESC_HIGH;
            DESC_HIGH: if (desc_fire) state_d = TAIL;
            TAIL: begin
                if (desc_fire) begin
                    tail_d     = new_tail_q;
                    sent_cnt_d = sent_cnt_q + 32'(cnt_q);
                    state_d    = IDLE;
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            tail_q       <= '0;
            start_q      <= '0;
            new_tail_q   <= '0;
            cnt_q        <= '0;
            low_q        <= '0;
            high_q       <= '0;
            idle_timer_q <= '0;
            sent_cnt_q   <= '0;
            kmem_q       <= '0;
            tail_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            tail_q       <= tail_d;
            start_q      <= start_d;
            new_tail_q   <= new_tail_d;
            cnt_q        <= cnt_d;
            low_q        <= low_d;
            high_q       <= high_d;
            idle_timer_q <= idle_timer_d;
            sent_cnt_q   <= sent_cnt_d;
            kmem_q       <= kmem_d;
            tail_addr_q  <= tail_addr_d;
        end
    end

    assign tail     = tail_q;
    assign sent_cnt = sent_cnt_q;

endmodule

// File: tb/tb_fpga2cpu_pcie.sv
// tb_fpga2cpu_pcie
//   Directed bench for fpga2cpu_pcie: a table of batch scenarios (prefill,
//   push count, expected launch latency, expected descriptors, tail and
//   sent count) plus hand-written sequences for back-pressure, reset,
//   ring-full gating and staging-RAM reads.
module tb_fpga2cpu_pcie;

    localparam logic [63:0] KMEM      = 64'h0000_0000_1000_0000;
    localparam logic [63:0] TAIL_ADDR = 64'h0000_0002_0000_0040;
    localparam logic [31:0] EP_BASE   = 32'h0008_0000;

    logic         clk, rst;
    logic         in_valid, in_ready;
    logic [511:0] in_data;
    logic [8:0]   head, tail;
    logic [63:0]  kmem_addr, cpu_f2c_tail_addr;
    logic         wrdm_desc_ready, wrdm_desc_valid;
    logic [173:0] wrdm_desc_data;
    logic         f2c_read;
    logic [8:0]   f2c_address;
    logic [511:0] f2c_readdata;
    logic         f2c_readdatavalid;
    logic [31:0]  sent_cnt;

    int checks = 0;
    int failures = 0;
    int seq = 0;

    logic [173:0] got_q [$];

    fpga2cpu_pcie dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .head              (head),
        .tail              (tail),
        .kmem_addr         (kmem_addr),
        .cpu_f2c_tail_addr (cpu_f2c_tail_addr),
        .wrdm_desc_ready   (wrdm_desc_ready),
        .wrdm_desc_valid   (wrdm_desc_valid),
        .wrdm_desc_data    (wrdm_desc_data),
        .f2c_read          (f2c_read),
        .f2c_address       (f2c_address),
        .f2c_readdata      (f2c_readdata),
        .f2c_readdatavalid (f2c_readdatavalid),
        .sent_cnt          (sent_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change #1 after posedge, so at negedge a valid&&ready pair is
    // exactly the handshake that the next posedge will take.
    always @(negedge clk)
        if (!rst && wrdm_desc_valid && wrdm_desc_ready) got_q.push_back(wrdm_desc_data);

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [511:0] pat(input int s);
        return {16{32'hC0DE_0000 ^ 32'(s)}};
    endfunction

    function automatic logic [173:0] dd(input int slot, input int n);
        logic [63:0] dst;
        logic [31:0] src;
        dst = KMEM + 64'(slot) * 64'd64;
        src = EP_BASE + 32'(slot) * 32'd64;
        return {14'h0, 32'(n * 16), dst, 32'h0, src};
    endfunction

    function automatic logic [173:0] td(input int nt);
        return {14'h0, 8'hFE, 3'b000, 1'b0, 1'b1, 19'd1, TAIL_ADDR, 32'h0, 23'h0, 9'(nt)};
    endfunction

    task automatic chk_w(input string nm, input logic [173:0] got, input logic [173:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic push(input int n);
        int done = 0;
        int guard = 0;
        while (done < n && guard < n + 1000) begin
            if (in_ready) begin
                in_valid = 1'b1;
                in_data  = pat(seq);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (in_valid) begin
                done++;
                seq++;
            end
            guard++;
        end
        in_valid = 1'b0;
        if (done < n) begin
            checks++;
            failures++;
            $display("FAIL push_timeout got=%0d exp=%0d", done, n);
        end
    endtask

    task automatic wait_tail(input int target, input int bound);
        int n = 0;
        while (int'(tail) != target && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        if (int'(tail) != target) begin
            checks++;
            failures++;
            $display("FAIL wait_tail got=%0d exp=%0d", tail, target);
        end
    endtask

    typedef struct {
        int           prefill;
        int           npush;
        int           exp_lat;
        int           exp_n;
        logic [173:0] d0, d1, d2;
        int           exp_tail;
        int           exp_sent;
    } scen_t;

    scen_t        scen [4];
    int           cur_tail;
    int           lat;
    int           acc;
    int           base;
    logic [173:0] exp_d;
    int           rd_slots [4];

    initial begin
        // prefill, npush, latency from last accept to valid, #desc, descs, tail, sent
        scen[0] = '{0,   8, 1,   2, dd(0, 8),   td(8),    '0,    8,  8};
        scen[1] = '{0,   3, 254, 2, dd(8, 3),   td(11),   '0,    11, 11};
        scen[2] = '{493, 8, 1,   2, dd(504, 8), td(0),    '0,    0,  512};
        scen[3] = '{508, 8, 1,   3, dd(508, 4), dd(0, 4), td(4), 4,  1028};
        rd_slots = '{0, 1, 255, 510};

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        head = '0;
        kmem_addr = KMEM;
        cpu_f2c_tail_addr = TAIL_ADDR;
        wrdm_desc_ready = 1'b1;
        f2c_read = 1'b0;
        f2c_address = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_i("rst_in_ready", int'(in_ready), 0);
        chk_i("rst_desc_valid", int'(wrdm_desc_valid), 0);
        chk_i("rst_tail", int'(tail), 0);
        chk_i("rst_sent_cnt", int'(sent_cnt), 0);
        chk_i("rst_rdvalid", int'(f2c_readdatavalid), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_i("post_rst_in_ready", int'(in_ready), 1);

        cur_tail = 0;
        for (int i = 0; i < 4; i++) begin
            head = 9'(cur_tail);
            if (scen[i].prefill > 0) begin
                push(scen[i].prefill);
                cur_tail = (cur_tail + scen[i].prefill) % 512;
                wait_tail(cur_tail, 3000);
                head = 9'(cur_tail);
            end
            got_q.delete();
            push(scen[i].npush);
            lat = 0;
            while (!wrdm_desc_valid && lat < 400) begin
                @(posedge clk); #1;
                lat++;
            end
            chk_i($sformatf("s%0d_latency", i), lat, scen[i].exp_lat);
            wait_tail(scen[i].exp_tail, 100);
            cur_tail = scen[i].exp_tail;
            chk_i($sformatf("s%0d_desc_count", i), got_q.size(), scen[i].exp_n);
            for (int k = 0; k < scen[i].exp_n; k++) begin
                exp_d = (k == 0) ? scen[i].d0 : (k == 1) ? scen[i].d1 : scen[i].d2;
                if (k < got_q.size()) chk_w($sformatf("s%0d_desc%0d", i, k), got_q[k], exp_d);
            end
            chk_i($sformatf("s%0d_tail", i), int'(tail), scen[i].exp_tail);
            chk_i($sformatf("s%0d_sent_cnt", i), int'(sent_cnt), scen[i].exp_sent);
        end

        // Back-pressure: descriptor held stable, tail frozen until the tail
        // descriptor itself is taken; then reset abandons the batch.
        head = 9'(cur_tail);
        wrdm_desc_ready = 1'b0;
        push(8);
        lat = 0;
        while (!wrdm_desc_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int c = 0; c < 10; c++) begin
            chk_i($sformatf("stall_valid_%0d", c), int'(wrdm_desc_valid), 1);
            chk_w($sformatf("stall_data_%0d", c), wrdm_desc_data, dd(4, 8));
            chk_i($sformatf("stall_tail_%0d", c), int'(tail), 4);
            @(posedge clk); #1;
        end
        wrdm_desc_ready = 1'b1;
        @(posedge clk); #1;
        wrdm_desc_ready = 1'b0;
        chk_w("stall_tail_desc", wrdm_desc_data, td(12));
        chk_i("stall_tail_pending", int'(tail), 4);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_i("midrst_valid", int'(wrdm_desc_valid), 0);
        chk_i("midrst_tail", int'(tail), 0);
        chk_i("midrst_in_ready", int'(in_ready), 0);
        chk_i("midrst_sent_cnt", int'(sent_cnt), 0);
        head = '0;
        rst = 1'b0;
        wrdm_desc_ready = 1'b1;
        @(posedge clk); #1;

        // Ring full: 511 accepted with head at 0, then head moves.
        base = seq;
        acc = 0;
        for (int g = 0; g < 600; g++) begin
            if (!in_ready) break;
            in_valid = 1'b1;
            in_data  = pat(seq);
            @(posedge clk); #1;
            seq++;
            acc++;
        end
        in_valid = 1'b0;
        chk_i("full_accepted", acc, 511);
        @(posedge clk); #1;
        chk_i("full_in_ready", int'(in_ready), 0);
        head = 9'd100;
        @(posedge clk); #1;
        chk_i("head_move_in_ready", int'(in_ready), 1);

        // Staging RAM reads: data and valid exactly two cycles after the read.
        for (int r = 0; r < 4; r++) begin
            f2c_read    = 1'b1;
            f2c_address = 9'(rd_slots[r]);
            @(posedge clk); #1;
            f2c_read = 1'b0;
            chk_i($sformatf("rd%0d_valid_early", r), int'(f2c_readdatavalid), 0);
            @(posedge clk); #1;
            chk_i($sformatf("rd%0d_valid", r), int'(f2c_readdatavalid), 1);
            checks++;
            if (f2c_readdata !== pat(base + rd_slots[r])) begin
                failures++;
                $display("FAIL rd%0d_data got=%h exp=%h", r, f2c_readdata[63:0],
                         pat(base + rd_slots[r]) >> 448);
            end
            @(posedge clk); #1;
            chk_i($sformatf("rd%0d_valid_after", r), int'(f2c_readdatavalid), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
